// File: rtl/sseg_pkg.sv
// Shared constants for seven-segment encode/decode: glyph table, widths and reader FSM encoding.
// Used by sseg_scan_reader and its glyph lookup (err counter enabled by SSEG_READER_ERRCNT_EN).
package sseg_pkg;

  localparam int SEG_W      = 8;
  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_PUBLISH = 2'd2
  } state_t;

  // Segment patterns {g,f,e,d,c,b,a} for hex digits 0..F.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [1:0] anode_to_idx(input logic [NUM_DIGITS-1:0] anode);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!anode[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sseg_glyph_to_hex.sv
// Combinational glyph lookup: 7-bit segment pattern to hex nibble.
// Unknown patterns (including all-off) give nibble 0 with illegal set.
module sseg_glyph_to_hex
  import sseg_pkg::*;
(
  input  logic [6:0] glyph,
  output logic [3:0] nibble,
  output logic       illegal
);

  always_comb begin
    nibble  = 4'h0;
    illegal = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (glyph == GLYPH_TABLE[i]) begin
        nibble  = 4'(i);
        illegal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sseg_scan_reader.sv
// Reads a multiplexed 4-digit seven-segment display back into a hex value.
// Define SSEG_READER_ERRCNT_EN to build the saturating illegal-glyph counter.
module sseg_scan_reader
  import sseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_DIGITS-1:0] anode,
  input  logic [SEG_W-1:0]      cathode,
  output logic [15:0]           value,
  output logic [NUM_DIGITS-1:0] dp,
  output logic [NUM_DIGITS-1:0] digit_err,
  output logic                  valid,
  output logic                  frame_done,
  output logic [7:0]            err_count
);

  localparam int CW = 9;
  localparam logic [CW-1:0] CNT_TGT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES + 1);

  // Handshake-free block: inputs are free-running display lines sampled every cycle.
  logic [NUM_DIGITS-1:0] anode_q;
  logic [SEG_W-1:0]      cathode_q;
  logic [CW-1:0]         cnt_q;
  logic                  chg_q;
  logic                  usable_in;

  state_t                state_q, state_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_base, seen_set;
  logic [15:0]           sh_value_q;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_err_q;

  logic                  cap, publish;
  logic [1:0]            cap_idx;
  logic [3:0]            cap_nibble;
  logic                  cap_illegal;

  assign usable_in = $onehot(~anode);

  // Counter saturates one past the target so the target is hit exactly once per stable run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_q   <= '1;
      cathode_q <= '0;
      cnt_q     <= '0;
      chg_q     <= 1'b1;
    end else begin
      anode_q   <= anode;
      cathode_q <= cathode;
      if (!usable_in) begin
        cnt_q <= '0;
        chg_q <= 1'b1;
      end else if ({anode, cathode} == {anode_q, cathode_q}) begin
        chg_q <= 1'b0;
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= CW'(1);
        chg_q <= 1'b1;
      end
    end
  end

  assign cap     = (cnt_q == CNT_TGT);
  assign cap_idx = anode_to_idx(anode_q);

  sseg_glyph_to_hex u_glyph (
    .glyph   (cathode_q[6:0]),
    .nibble  (cap_nibble),
    .illegal (cap_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_SETTLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SETTLE: if (cap) state_d = (seen_set == '1) ? ST_PUBLISH : ST_HOLD;
      ST_HOLD: begin
        if (cap)        state_d = (seen_set == '1) ? ST_PUBLISH : ST_HOLD;
        else if (chg_q) state_d = ST_SETTLE;
      end
      ST_PUBLISH: state_d = cap ? ST_HOLD : ST_SETTLE;
      default:    state_d = ST_SETTLE;
    endcase
  end

  always_comb begin
    publish   = (state_q == ST_PUBLISH);
    seen_base = publish ? '0 : seen_q;
    seen_set  = seen_base | (cap ? NUM_DIGITS'(1) << cap_idx : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q     <= '0;
      sh_value_q <= '0;
      sh_dp_q    <= '0;
      sh_err_q   <= '0;
    end else begin
      seen_q <= (state_d == ST_PUBLISH) ? '0 : seen_set;
      if (cap) begin
        sh_value_q[4*cap_idx +: 4] <= cap_nibble;
        sh_dp_q[cap_idx]           <= cathode_q[7];
        sh_err_q[cap_idx]          <= cap_illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value      <= '0;
      dp         <= '0;
      digit_err  <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= publish;
      if (publish) begin
        value     <= sh_value_q;
        dp        <= sh_dp_q;
        digit_err <= sh_err_q;
        valid     <= 1'b1;
      end
    end
  end

`ifdef SSEG_READER_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         err_cnt_q <= 8'h00;
    else if (cap && cap_illegal && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'h01;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_sseg_scan_reader.sv
// Directed scenarios plus randomized scanning, checked against a stream-level model of the reader.
module tb_sseg_scan_reader;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  anode = 4'hF;
  logic [7:0]  cathode = 8'h00;
  logic [15:0] value;
  logic [3:0]  dp, digit_err;
  logic        valid, frame_done;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;
  int fd_seen = 0;

  always #5 clk = ~clk;

  sseg_scan_reader #(.STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .anode      (anode),
    .cathode    (cathode),
    .value      (value),
    .dp         (dp),
    .digit_err  (digit_err),
    .valid      (valid),
    .frame_done (frame_done),
    .err_count  (err_count)
  );

  logic [6:0] gt [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: run length of identical usable samples over the input stream.
  int          run;
  logic [11:0] prev;
  bit          cap_pend, pub_pend;
  logic [11:0] cap_s;
  logic [3:0]  seen;
  logic [15:0] sh_val, m_value;
  logic [3:0]  sh_dp, sh_err, m_dp, m_err;
  logic        m_valid, m_fd;
  int          m_errcnt;

  task automatic model_reset();
    run = 0; prev = 12'hFFF; cap_pend = 0; pub_pend = 0; cap_s = '0; seen = '0;
    sh_val = '0; sh_dp = '0; sh_err = '0;
    m_value = '0; m_dp = '0; m_err = '0; m_valid = 0; m_fd = 0; m_errcnt = 0;
  endtask

  task automatic model_edge(input logic [3:0] a, input logic [7:0] c);
    int idx, zeros, nib;
    bit ill;
    m_fd = 0;
    if (pub_pend) begin
      m_value = sh_val; m_dp = sh_dp; m_err = sh_err; m_valid = 1; m_fd = 1; pub_pend = 0;
    end
    if (cap_pend) begin
      cap_pend = 0;
      idx = 0;
      for (int i = 0; i < 4; i++) if (!cap_s[8+i]) idx = i;
      nib = 0; ill = 1;
      for (int g = 0; g < 16; g++) if (cap_s[6:0] == gt[g]) begin nib = g; ill = 0; end
      sh_val[idx*4 +: 4] = 4'(nib);
      sh_dp[idx] = cap_s[7];
      sh_err[idx] = ill;
      seen[idx] = 1'b1;
`ifdef SSEG_READER_ERRCNT_EN
      if (ill && m_errcnt < 255) m_errcnt++;
`endif
      if (seen == 4'hF) begin pub_pend = 1; seen = '0; end
    end
    zeros = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) zeros++;
    if (zeros != 1) run = 0;
    else if (run > 0 && {a, c} == prev) run++;
    else run = 1;
    prev = {a, c};
    if (run == S) begin cap_pend = 1; cap_s = {a, c}; end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".value"}, value, m_value);
    check({tag, ".dp"}, 16'(dp), 16'(m_dp));
    check({tag, ".digit_err"}, 16'(digit_err), 16'(m_err));
    check({tag, ".valid"}, 16'(valid), 16'(m_valid));
    check({tag, ".frame_done"}, 16'(frame_done), 16'(m_fd));
    check({tag, ".err_count"}, 16'(err_count), 16'(m_errcnt));
  endtask

  task automatic step(input logic [3:0] a, input logic [7:0] c);
    @(negedge clk);
    anode = a; cathode = c;
    @(posedge clk);
    model_edge(a, c);
    #1;
    compare_all("step");
    if (frame_done === 1'b1) fd_seen++;
  endtask

  task automatic visit(input int d, input logic [7:0] c, input int n);
    logic [3:0] one;
    one = 4'b0001 << d;
    repeat (n) step(~one, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int fd_base, d, n, r;
    logic [7:0] c;
    model_reset();
    #2;
    compare_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame 0..3
    fd_base = fd_seen;
    visit(0, 8'h3F, 4); visit(1, 8'h06, 4); visit(2, 8'h5B, 4); visit(3, 8'h4F, 4);
    step(4'hF, 8'h00);
    check("basic.no_early_fd", 16'(fd_seen - fd_base), 16'd0);
    step(4'hF, 8'h00);
    check("basic.frame_done", 16'(frame_done), 16'd1);
    check("basic.value", value, 16'h3210);
    check("basic.valid", 16'(valid), 16'd1);
    check("basic.digit_err", 16'(digit_err), 16'd0);

    // Unusable anodes: nothing changes
    fd_base = fd_seen;
    repeat (10) step(4'b1100, 8'($urandom_range(0, 255)));
    repeat (10) step(4'b1111, 8'($urandom_range(0, 255)));
    check("blank.value", value, 16'h3210);
    check("blank.no_fd", 16'(fd_seen - fd_base), 16'd0);

    // Short visit to digit 2 is not captured
    fd_base = fd_seen;
    visit(0, 8'h6D, 4); visit(1, 8'h7D, 4); visit(2, 8'h07, 3); visit(3, 8'h6F, 4);
    repeat (3) step(4'hF, 8'h00);
    check("short.no_fd", 16'(fd_seen - fd_base), 16'd0);
    visit(2, 8'h77, 4);
    repeat (2) step(4'hF, 8'h00);
    check("short.fd", 16'(fd_seen - fd_base), 16'd1);
    check("short.value", value, 16'h9A65);

    // Illegal glyphs and dp
    visit(0, 8'h3F, 4); visit(1, 8'h00, 4); visit(2, 8'h5B, 4); visit(3, 8'hFF, 4);
    repeat (2) step(4'hF, 8'h00);
    check("illegal.digit_err", 16'(digit_err), 16'h0002);
    check("illegal.dp", 16'(dp), 16'h0008);
    check("illegal.value", value, 16'h8200);
`ifdef SSEG_READER_ERRCNT_EN
    check("illegal.err_count", 16'(err_count), 16'h0001);
`else
    check("illegal.err_count", 16'(err_count), 16'h0000);
`endif

    // Randomized scanning
    for (int v = 0; v < 120; v++) begin
      d = $urandom_range(0, 3);
      r = $urandom_range(0, 7);
      if (r == 0) c = 8'($urandom_range(0, 255));
      else c = {1'($urandom_range(0, 1)), gt[$urandom_range(0, 15)]};
      n = $urandom_range(1, 7);
      visit(d, c, n);
      if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 3)) step(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end

    // Reset after three captures discards the partial frame
    do_reset();
    fd_base = fd_seen;
    visit(0, 8'h06, 4); visit(1, 8'h5B, 4); visit(2, 8'h4F, 4);
    step(4'hF, 8'h00);
    do_reset();
    check("rst.value", value, 16'h0000);
    check("rst.valid", 16'(valid), 16'd0);
    visit(3, 8'h66, 4);
    repeat (3) step(4'hF, 8'h00);
    check("rst.no_fd", 16'(fd_seen - fd_base), 16'd0);
    visit(0, 8'h3F, 4); visit(1, 8'h3F, 4); visit(2, 8'h3F, 4);
    repeat (2) step(4'hF, 8'h00);
    check("rst.fd", 16'(fd_seen - fd_base), 16'd1);
    check("rst.value2", value, 16'h4000);

    // 300 illegal captures
    for (int i = 0; i < 150; i++) begin
      visit(0, 8'h00, 4);
      visit(1, 8'h00, 4);
    end
    repeat (2) step(4'hF, 8'h00);
`ifdef SSEG_READER_ERRCNT_EN
    check("sat.err_count", 16'(err_count), 16'h00FF);
`else
    check("sat.err_count", 16'(err_count), 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sseg_scan_reader.md
SSEG_SCAN_READER -- requirements
Module: sseg_scan_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is captured (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port anode  input  4  active-low digit select from the scanned display; bit i low selects digit i.
REQ-005 SHALL have port cathode  input  8  active-high segments {dp,g,f,e,d,c,b,a}; digit 0 pattern is 8'b00111111.
REQ-006 SHALL have port value  output  16  captured hex value, digit i in bits [4i+3:4i].
REQ-007 SHALL have port dp  output  4  captured decimal-point bit per digit.
REQ-008 SHALL have port digit_err  output  4  per-digit flag: captured pattern not a legal hex glyph.
REQ-009 SHALL have port valid  output  1  high once the first complete frame has been published; stays high until reset.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when value/dp/digit_err are updated.
REQ-011 SHALL have port err_count  output  8  saturating illegal-glyph counter (see Configuration).

Function
REQ-012 SHALL decode the glyph table 0-F (gfedcba): 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71; dp (bit 7) is ignored for lookup.
REQ-013 SHALL treat a sample as usable only when anode has exactly one bit low; an all-high or multi-low anode SHALL clear the stability counter and capture nothing.
REQ-014 SHALL register {anode,cathode} each cycle and increment the stability counter while the sample equals the previous one, clearing it to 1 on any change.
REQ-015 SHALL use states SETTLE (counting), HOLD (digit already captured, waiting for a change of sample) and PUBLISH (one cycle, updating outputs).
REQ-016 SHALL transition SETTLE->HOLD on the cycle the counter reaches STABLE_CYCLES, capturing that digit's nibble, dp bit and error flag into a shadow register and setting its seen bit.
REQ-017 SHALL transition HOLD->SETTLE on any change of sample, so each digit visit is captured at most once.
REQ-018 SHALL enter PUBLISH on the cycle after the capture that makes all four seen bits set, then copy shadow to value/dp/digit_err, pulse frame_done, clear seen bits and return to SETTLE.
REQ-019 SHALL let a repeated capture of an already-seen digit overwrite its shadow entry without affecting seen bits.
REQ-020 SHALL store nibble 4'h0 and set the digit_err bit for any illegal glyph, including all-segments-off.
REQ-021 SHALL keep published outputs stable between frame_done pulses regardless of input activity.

Reset
REQ-022 SHALL on rst_n low immediately force value=16'h0000, dp=4'h0, digit_err=4'h0, valid=0, frame_done=0, err_count=8'h00, seen bits clear, counter 0, state SETTLE.
REQ-023 SHALL discard any partial frame when reset asserts mid-frame; the first frame_done after release requires four fresh captures.

Configuration
REQ-024 SHALL with SSEG_READER_ERRCNT_EN defined increment err_count by 1 per illegal-glyph capture, saturating at 8'hFF, cleared only by reset.
REQ-025 SHALL without SSEG_READER_ERRCNT_EN tie err_count to 8'h00 and omit the counter logic; all other behaviour is identical.

Structure
REQ-026 SHALL take the 16 glyph constants, SEG_W=8, NUM_DIGITS=4 and the state encoding from shared package sseg_pkg, also used by SSEG_Decoder.
REQ-027 SHALL place glyph-to-hex lookup in combinational sub-module sseg_glyph_to_hex (in: 7-bit glyph; out: 4-bit nibble, 1-bit illegal).

Verification
REQ-028 SHALL cover: scan digits 0..3 with glyphs 3F,06,5B,4F (anode 1110,1101,1011,0111), 4 cycles each -> frame_done one cycle after the last capture, value=16'h3210, valid=1, digit_err=0.
REQ-029 SHALL cover: digit 2 held only 3 cycles then changed -> no capture for digit 2, no frame_done until a later 4-cycle visit to digit 2.
REQ-030 SHALL cover: anode=1100 or 1111 for 10 cycles -> no capture, counter cleared, outputs unchanged.
REQ-031 SHALL cover: digit 1 glyph 8'h00 and digit 3 glyph 8'hFF (dp set, lookup 7F) -> digit_err=4'b0010, dp=4'b1000, nibble1=0, nibble3=8; with macro, err_count=1.
REQ-032 SHALL cover: reset pulsed after three captures -> all outputs 0 immediately; next frame_done requires four new captures.
REQ-033 SHALL cover (macro on): 300 illegal captures -> err_count saturates at 8'hFF.
